seq_datapath: RTL and testbench

SEQ_DATAPATH -- requirements
Module: seq_datapath

---
 rtl/seq_pkg.sv | 29 ++
 rtl/seq_stack.sv | 51 +++++
 rtl/seq_datapath.sv | 82 ++++++++
 tb/tb_seq_datapath.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the microsequencer datapath: default widths and the
// command encodings that the instruction decoder drives onto the control fields.
package seq_pkg;

  localparam int DEF_ADDR_W      = 12;
  localparam int DEF_STACK_DEPTH = 5;

  typedef enum logic [1:0] {
    STK_HOLD  = 2'b00,
    STK_PUSH  = 2'b01,
    STK_POP   = 2'b10,
    STK_RESET = 2'b11
  } stack_op_e;

  typedef enum logic [1:0] {
    RC_HOLD = 2'b00,
    RC_LOAD = 2'b01,
    RC_DEC  = 2'b10,
    RC_RSVD = 2'b11
  } rc_op_e;

  typedef enum logic [1:0] {
    Y_UPC = 2'b00,
    Y_D   = 2'b01,
    Y_R   = 2'b10,
    Y_F   = 2'b11
  } y_sel_e;

endpackage

// File: rtl/seq_stack.sv
// Subroutine return stack: storage, pointer, top-of-stack read and full flag.
// Pushing into a full stack overwrites the top entry instead of growing.
module seq_stack
  import seq_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        stack_op,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] tos,
  output logic              full_n
);

  localparam int              SP_W    = $clog2(STACK_DEPTH + 1);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);
  localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);

  logic [ADDR_W-1:0] mem [STACK_DEPTH];
  logic [SP_W-1:0]   sp;
  logic [SP_W-1:0]   wr_idx;
  logic [SP_W-1:0]   rd_idx;

  assign wr_idx = (sp == SP_FULL) ? (SP_FULL - SP_ONE) : sp;
  assign rd_idx = sp - SP_ONE;
  assign tos    = (sp == '0) ? '0 : mem[rd_idx];
  assign full_n = (sp != SP_FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= '0;
    end else begin
      case (stack_op)
        STK_PUSH:  if (sp != SP_FULL) sp <= sp + SP_ONE;
        STK_POP:   if (sp != '0) sp <= sp - SP_ONE;
        STK_RESET: sp <= '0;
        default:   sp <= sp;
      endcase
    end
  end

  // Entries are data only: never cleared, written only on a non-reset push.
  always_ff @(posedge clk) begin
    if (!rst && stack_op == STK_PUSH) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/seq_datapath.sv
// Microsequencer address datapath: uPC, loop counter R/C and the Y source mux,
// with the return stack in seq_stack. Y is purely combinational.
module seq_datapath
  import seq_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] d,
  input  logic [1:0]        stack_op,
  input  logic [1:0]        rc_op,
  input  logic [1:0]        y_mux_sel,
  input  logic              y_zero,
  input  logic              ci,
  input  logic              rld_n,
  output logic [ADDR_W-1:0] y,
  output logic              rc_is_zero,
  output logic              full_n
);

  logic [ADDR_W-1:0] upc;
  logic [ADDR_W-1:0] rc;
  logic [ADDR_W-1:0] tos;

  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a,
                                                 input logic c);
    return a + {{(ADDR_W-1){1'b0}}, c};
  endfunction

  function automatic logic [ADDR_W-1:0] wrap_dec(input logic [ADDR_W-1:0] a);
    return a - {{(ADDR_W-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    y = '0;
    if (!y_zero) begin
      case (y_mux_sel)
        Y_UPC:   y = upc;
        Y_D:     y = d;
        Y_R:     y = rc;
        default: y = tos;
      endcase
    end
  end

  assign rc_is_zero = (rc == '0);

  always_ff @(posedge clk) begin
    if (rst) upc <= '0;
    else     upc <= wrap_inc(y, ci);
  end

  // Forced load via rld_n outranks any counter command.
  always_ff @(posedge clk) begin
    if (rst) begin
      rc <= '0;
    end else if (!rld_n) begin
      rc <= d;
    end else begin
      case (rc_op)
        RC_LOAD: rc <= d;
        RC_DEC:  rc <= wrap_dec(rc);
        default: rc <= rc;
      endcase
    end
  end

  seq_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .stack_op  (stack_op),
    .push_data (upc),
    .tos       (tos),
    .full_n    (full_n)
  );

endmodule

// File: tb/tb_seq_datapath.sv
// Bench for seq_datapath: directed scenarios plus randomized traffic checked
// against a queue-based behavioural model of uPC, R/C and the return stack.
module tb_seq_datapath;

  localparam int AW    = 12;
  localparam int DEPTH = 5;
  localparam int MOD   = 4096;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] d;
  logic [1:0]    stack_op;
  logic [1:0]    rc_op;
  logic [1:0]    y_mux_sel;
  logic          y_zero;
  logic          ci;
  logic          rld_n;
  logic [AW-1:0] y;
  logic          rc_is_zero;
  logic          full_n;

  int n_checks = 0;
  int n_fail   = 0;

  int m_upc = 0;
  int m_rc  = 0;
  int m_stk[$];

  seq_datapath #(.ADDR_W(AW), .STACK_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .d          (d),
    .stack_op   (stack_op),
    .rc_op      (rc_op),
    .y_mux_sel  (y_mux_sel),
    .y_zero     (y_zero),
    .ci         (ci),
    .rld_n      (rld_n),
    .y          (y),
    .rc_is_zero (rc_is_zero),
    .full_n     (full_n)
  );

  always #5 clk = ~clk;

  function automatic int m_tos();
    return (m_stk.size() == 0) ? 0 : m_stk[$];
  endfunction

  function automatic int m_y();
    if (y_zero) return 0;
    case (y_mux_sel)
      2'd0:    return m_upc;
      2'd1:    return int'(d);
      2'd2:    return m_rc;
      default: return m_tos();
    endcase
  endfunction

  task automatic idle();
    stack_op  = 2'd0;
    rc_op     = 2'd0;
    y_mux_sel = 2'd0;
    y_zero    = 1'b0;
    ci        = 1'b0;
    rld_n     = 1'b1;
    d         = '0;
  endtask

  // One clock: advance the model from the inputs in force, then settle.
  task automatic tick();
    int yv;
    int old_upc;
    yv      = m_y();
    old_upc = m_upc;
    @(posedge clk);
    if (rst) begin
      m_upc = 0;
      m_rc  = 0;
      m_stk.delete();
    end else begin
      m_upc = (yv + int'(ci)) % MOD;
      if (!rld_n || rc_op == 2'd1) m_rc = int'(d);
      else if (rc_op == 2'd2)      m_rc = (m_rc + MOD - 1) % MOD;
      case (stack_op)
        2'd1: begin
          if (m_stk.size() < DEPTH) m_stk.push_back(old_upc);
          else                      m_stk[m_stk.size()-1] = old_upc;
        end
        2'd2: if (m_stk.size() > 0) void'(m_stk.pop_back());
        2'd3: m_stk.delete();
        default: ;
      endcase
    end
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (y !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_y: got %h expected 000", y);
    end
    n_checks++;
    if (rc_is_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_rc_is_zero: got %b expected 1", rc_is_zero);
    end
    n_checks++;
    if (full_n !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_full_n: got %b expected 1", full_n);
    end
  endtask

  task automatic test_upc_count();
    logic [AW-1:0] exp;
    idle();
    ci = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      exp = AW'(i);
      n_checks++;
      if (y !== exp) begin
        n_fail++;
        $display("FAIL upc_count[%0d]: got %h expected %h", i, y, exp);
      end
      tick();
    end
  endtask

  task automatic test_push_pop();
    idle();
    d = 12'h123;
    y_mux_sel = 2'd1;
    stack_op = 2'd1;
    #1;
    n_checks++;
    if (y !== 12'h123) begin
      n_fail++;
      $display("FAIL push_y_d: got %h expected 123", y);
    end
    tick();
    idle();
    y_mux_sel = 2'd3;
    stack_op = 2'd2;
    #1;
    n_checks++;
    if (y !== 12'h003) begin
      n_fail++;
      $display("FAIL pop_tos: got %h expected 003", y);
    end
    tick();
    stack_op = 2'd0;
    #1;
    n_checks++;
    if (y !== 12'h000) begin
      n_fail++;
      $display("FAIL empty_tos: got %h expected 000", y);
    end
  endtask

  task automatic test_stack_full();
    logic [AW-1:0] pops [5] = '{12'h015, 12'h013, 12'h012, 12'h011, 12'h010};
    logic [AW-1:0] exp;
    logic          exp_full_n;
    idle();
    d = 12'h010;
    y_mux_sel = 2'd1;
    tick();
    idle();
    ci = 1'b1;
    stack_op = 2'd1;
    for (int i = 0; i < 6; i++) begin
      #1;
      exp = AW'(12'h010 + i);
      n_checks++;
      if (y !== exp) begin
        n_fail++;
        $display("FAIL push_upc[%0d]: got %h expected %h", i, y, exp);
      end
      tick();
      exp_full_n = (i >= 4) ? 1'b0 : 1'b1;
      n_checks++;
      if (full_n !== exp_full_n) begin
        n_fail++;
        $display("FAIL full_n_after_push[%0d]: got %b expected %b", i, full_n, exp_full_n);
      end
    end
    idle();
    y_mux_sel = 2'd3;
    stack_op = 2'd2;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (y !== pops[i]) begin
        n_fail++;
        $display("FAIL pop_seq[%0d]: got %h expected %h", i, y, pops[i]);
      end
      tick();
    end
    tick();
    #1;
    n_checks++;
    if (y !== 12'h000 || full_n !== 1'b1) begin
      n_fail++;
      $display("FAIL pop_empty: got y=%h full_n=%b expected y=000 full_n=1", y, full_n);
    end
  endtask

  task automatic test_rc_dec();
    logic [AW-1:0] exp;
    idle();
    rld_n = 1'b0;
    rc_op = 2'd2;
    d = 12'h003;
    tick();
    rld_n = 1'b1;
    y_mux_sel = 2'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      exp = AW'(3 - i);
      n_checks++;
      if (y !== exp || rc_is_zero !== 1'b0) begin
        n_fail++;
        $display("FAIL rc_dec[%0d]: got rc=%h zero=%b expected rc=%h zero=0", i, y, rc_is_zero, exp);
      end
      tick();
    end
    n_checks++;
    if (rc_is_zero !== 1'b1 || y !== 12'h000) begin
      n_fail++;
      $display("FAIL rc_zero: got rc=%h zero=%b expected rc=000 zero=1", y, rc_is_zero);
    end
    tick();
    n_checks++;
    if (y !== 12'hFFF || rc_is_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL rc_wrap: got rc=%h zero=%b expected rc=fff zero=0", y, rc_is_zero);
    end
  endtask

  task automatic test_load_yzero();
    idle();
    rc_op = 2'd1;
    d = 12'h0A5;
    y_zero = 1'b1;
    y_mux_sel = 2'd1;
    ci = 1'b1;
    #1;
    n_checks++;
    if (y !== 12'h000) begin
      n_fail++;
      $display("FAIL y_zero: got %h expected 000", y);
    end
    tick();
    idle();
    y_mux_sel = 2'd2;
    #1;
    n_checks++;
    if (y !== 12'h0A5) begin
      n_fail++;
      $display("FAIL rc_load: got %h expected 0a5", y);
    end
    y_mux_sel = 2'd0;
    #1;
    n_checks++;
    if (y !== 12'h001) begin
      n_fail++;
      $display("FAIL upc_after_jz: got %h expected 001", y);
    end
  endtask

  task automatic test_reset_priority();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ci = 1'b1;
    stack_op = 2'd1;
    rld_n = 1'b0;
    d = 12'h007;
    repeat (3) tick();
    idle();
    y_mux_sel = 2'd3;
    #1;
    n_checks++;
    if (y !== 12'h002) begin
      n_fail++;
      $display("FAIL pre_rst_tos: got %h expected 002", y);
    end
    rst = 1'b1;
    stack_op = 2'd1;
    rld_n = 1'b0;
    d = 12'h055;
    tick();
    rst = 1'b0;
    idle();
    #1;
    n_checks++;
    if (y !== 12'h000 || rc_is_zero !== 1'b1 || full_n !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_priority: got upc=%h zero=%b full_n=%b expected 000/1/1", y, rc_is_zero, full_n);
    end
    y_mux_sel = 2'd3;
    #1;
    n_checks++;
    if (y !== 12'h000) begin
      n_fail++;
      $display("FAIL rst_priority_tos: got %h expected 000", y);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] exp_y;
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 39) == 0);
      d         = AW'($urandom_range(0, MOD - 1));
      stack_op  = 2'($urandom_range(0, 3));
      rc_op     = 2'($urandom_range(0, 3));
      y_mux_sel = 2'($urandom_range(0, 3));
      y_zero    = ($urandom_range(0, 7) == 0);
      ci        = 1'($urandom_range(0, 1));
      rld_n     = ($urandom_range(0, 5) != 0);
      #1;
      exp_y = AW'(m_y());
      n_checks++;
      if (y !== exp_y) begin
        n_fail++;
        $display("FAIL rand_y[%0d]: got %h expected %h", i, y, exp_y);
      end
      n_checks++;
      if (rc_is_zero !== (m_rc == 0)) begin
        n_fail++;
        $display("FAIL rand_rc_is_zero[%0d]: got %b expected %b", i, rc_is_zero, (m_rc == 0));
      end
      n_checks++;
      if (full_n !== (m_stk.size() != DEPTH)) begin
        n_fail++;
        $display("FAIL rand_full_n[%0d]: got %b expected %b", i, full_n, (m_stk.size() != DEPTH));
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #2;
    test_reset();
    test_upc_count();
    test_push_pop();
    test_stack_full();
    test_rc_dec();
    test_load_yzero();
    test_reset_priority();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
